ifm_axis_word_buffer: RTL and testbench

- Ingress stage directly upstream of the IFM byte-slicing parser.
- Accepts 512-bit AXI-Stream feature-map beats from the DMA into a small circular FIFO.
- Presents the head word on fm with ifm_read qualifying it; the parser's input_req pulse pops the head.
- Owns per-frame control: conv_start arms a frame, tlast closes intake, frame_done reports the drain.

---
 rtl/ifm_axis_word_buffer_if.sv | 25 ++
 rtl/ifm_axis_word_buffer.sv | 121 ++++++++++++
 tb/tb_ifm_axis_word_buffer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_axis_word_buffer_if.sv
// Purpose: bundles the AXIS ingress beat handshake and the parser-side head-word
//          handshake of the IFM word buffer into one port.
// Ports:   s_axis_tdata/tvalid/tlast/tready (DMA side), fm/ifm_read/input_req (parser side).
//          slave = the buffer; master = the DMA + parser pair driving it.
interface ifm_axis_word_buffer_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] fm;
  logic                  ifm_read;
  logic                  input_req;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, input_req,
    output s_axis_tready, fm, ifm_read
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, input_req,
    input  s_axis_tready, fm, ifm_read
  );
endinterface

// File: rtl/ifm_axis_word_buffer.sv
// Purpose: small circular FIFO between the feature-map DMA and the IFM byte-slicing parser,
//          with per-frame control (conv_start arms, tlast closes intake, frame_done on drain).
// Latency: a beat accepted into an empty buffer is on fm/ifm_read the cycle after its edge;
//          after a pop the next word is on fm the cycle after the pop edge.
// Backpressure: s_axis_tready only in RUN and below full, derived from registered state only;
//          a pop at full re-opens tready on the following cycle.
// Ports:   clk, rst (async, active-high); conv_start pulse; bus (slave modport of
//          ifm_axis_word_buffer_if); level, words_popped, frame_done pulse, sticky underflow.
module ifm_axis_word_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 conv_start,
  ifm_axis_word_buffer_if.slave bus,
  output logic [ADDR_W:0]      level,
  output logic [CNT_W-1:0]     words_popped,
  output logic                 frame_done,
  output logic                 underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_LEVEL  = (ADDR_W + 1)'(1);

  state_t                state;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;

  assign not_empty = (level != '0);
  assign not_full  = (level != FULL_LEVEL);

  // Ready depends only on state and level, never on input_req, so a pop at full
  // re-opens intake one cycle later rather than combinationally.
  assign bus.s_axis_tready = (state == RUN) && not_full;
  assign push              = bus.s_axis_tvalid && bus.s_axis_tready;
  assign pop               = bus.input_req && not_empty;

  // Head word is forced to zero when empty so stale storage never leaks to the parser.
  assign bus.ifm_read = not_empty && (state != IDLE);
  assign bus.fm       = not_empty ? mem[rd_ptr] : '0;

  // Storage is intentionally not reset; level gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.s_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      words_popped <= '0;
      frame_done   <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        words_popped <= words_popped + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      if (bus.input_req && !not_empty) begin
        underflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Level is always zero here, so no push/pop can collide with the clear.
          if (conv_start) begin
            state        <= RUN;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            words_popped <= '0;
            underflow    <= 1'b0;
          end
        end
        RUN: begin
          if (push && bus.s_axis_tlast) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // No pushes in DRAIN, so the pop at level 1 is the last word of the frame.
          if (pop && (level == ONE_LEVEL)) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_axis_word_buffer.sv
// Purpose: directed self-checking bench for ifm_axis_word_buffer (DEPTH=4, 512-bit words).
// Ports:   none; drives the DUT through an ifm_axis_word_buffer_if instance.
module tb_ifm_axis_word_buffer;

  logic        clk;
  logic        rst;
  logic        conv_start;
  logic [2:0]  level;
  logic [15:0] words_popped;
  logic        frame_done;
  logic        underflow;

  int checks;
  int errors;

  ifm_axis_word_buffer_if #(.DATA_WIDTH(512)) bus ();

  ifm_axis_word_buffer #(
    .DATA_WIDTH(512),
    .DEPTH(4),
    .ADDR_W(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .conv_start(conv_start),
    .bus(bus),
    .level(level),
    .words_popped(words_popped),
    .frame_done(frame_done),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input logic [7:0] tag, input int i);
    logic [31:0] w;
    w = {tag, 24'(i)};
    return {16{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    conv_start = 1'b1;
    step();
    conv_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", bus.s_axis_tready); end
    checks++; if (bus.ifm_read !== 1'b0) begin errors++; $display("FAIL reset_ifm_read got %b exp 0", bus.ifm_read); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (words_popped !== 16'd0) begin errors++; $display("FAIL reset_words_popped got %0d exp 0", words_popped); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
    checks++; if (bus.fm !== 512'd0) begin errors++; $display("FAIL reset_fm got %h exp 0", bus.fm); end
    rst = 1'b0;
    step();
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL idle_tready got %b exp 0", bus.s_axis_tready); end
  endtask

  task automatic test_basic_frame();
    start_frame();
    for (int i = 0; i < 4; i++) begin
      bus.s_axis_tdata  = pat(8'hD0, i);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = (i == 3);
      checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL basic_tready%0d got %b exp 1", i, bus.s_axis_tready); end
      step();
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL basic_level%0d got %0d exp %0d", i, level, i + 1); end
      if (i == 0) begin
        checks++; if (bus.ifm_read !== 1'b1) begin errors++; $display("FAIL basic_first_ifm_read got %b exp 1", bus.ifm_read); end
        checks++; if (bus.fm !== pat(8'hD0, 0)) begin errors++; $display("FAIL basic_first_fm got %h exp %h", bus.fm, pat(8'hD0, 0)); end
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL basic_drain_tready got %b exp 0", bus.s_axis_tready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.fm !== pat(8'hD0, i)) begin errors++; $display("FAIL basic_fm%0d got %h exp %h", i, bus.fm, pat(8'hD0, i)); end
      bus.input_req = 1'b1;
      step();
      bus.input_req = 1'b0;
      checks++; if (words_popped !== 16'(i + 1)) begin errors++; $display("FAIL basic_popped%0d got %0d exp %0d", i, words_popped, i + 1); end
      checks++; if (frame_done !== (i == 3)) begin errors++; $display("FAIL basic_frame_done%0d got %b exp %b", i, frame_done, (i == 3)); end
      if (i < 3) begin
        repeat (3) step();
      end
    end
    step();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_frame_done_width got %b exp 0", frame_done); end
    checks++; if (bus.ifm_read !== 1'b0) begin errors++; $display("FAIL basic_end_ifm_read got %b exp 0", bus.ifm_read); end
    checks++; if (bus.fm !== 512'd0) begin errors++; $display("FAIL basic_end_fm got %h exp 0", bus.fm); end
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL basic_end_tready got %b exp 0", bus.s_axis_tready); end
  endtask

  task automatic test_full_backpressure();
    start_frame();
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.s_axis_tdata = pat(8'hE0, k);
      step();
    end
    bus.s_axis_tdata = pat(8'hE0, 4);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", level); end
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b exp 0", bus.s_axis_tready); end
    repeat (2) step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_hold_level got %0d exp 4", level); end
    checks++; if (bus.fm !== pat(8'hE0, 0)) begin errors++; $display("FAIL full_head got %h exp %h", bus.fm, pat(8'hE0, 0)); end
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL full_reopen_tready got %b exp 1", bus.s_axis_tready); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_after_pop_level got %0d exp 3", level); end
    checks++; if (bus.fm !== pat(8'hE0, 1)) begin errors++; $display("FAIL full_after_pop_fm got %h exp %h", bus.fm, pat(8'hE0, 1)); end
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_fifth_level got %0d exp 4", level); end
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_fifth_tready got %b exp 0", bus.s_axis_tready); end
    bus.s_axis_tdata = pat(8'hE0, 5);
    bus.s_axis_tlast = 1'b1;
    bus.input_req    = 1'b1;
    step();
    bus.input_req = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop2_level got %0d exp 3", level); end
    step();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_sixth_level got %0d exp 4", level); end
    for (int k = 2; k < 6; k++) begin
      checks++; if (bus.fm !== pat(8'hE0, k)) begin errors++; $display("FAIL full_order%0d got %h exp %h", k, bus.fm, pat(8'hE0, k)); end
      bus.input_req = 1'b1;
      step();
      bus.input_req = 1'b0;
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL full_frame_done got %b exp 1", frame_done); end
    checks++; if (words_popped !== 16'd6) begin errors++; $display("FAIL full_popped got %0d exp 6", words_popped); end
    step();
  endtask

  task automatic test_simultaneous();
    start_frame();
    bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.s_axis_tdata = pat(8'hF0, k);
      step();
    end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_prefill_level got %0d exp 2", level); end
    for (int i = 0; i < 10; i++) begin
      bus.s_axis_tdata = pat(8'hF0, i + 2);
      bus.s_axis_tlast = (i == 9);
      bus.input_req    = 1'b1;
      checks++; if (bus.fm !== pat(8'hF0, i)) begin errors++; $display("FAIL simul_fm%0d got %h exp %h", i, bus.fm, pat(8'hF0, i)); end
      step();
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_level%0d got %0d exp 2", i, level); end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL simul_drain_tready got %b exp 0", bus.s_axis_tready); end
    for (int i = 10; i < 12; i++) begin
      checks++; if (bus.fm !== pat(8'hF0, i)) begin errors++; $display("FAIL simul_fm%0d got %h exp %h", i, bus.fm, pat(8'hF0, i)); end
      step();
    end
    bus.input_req = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL simul_frame_done got %b exp 1", frame_done); end
    checks++; if (words_popped !== 16'd12) begin errors++; $display("FAIL simul_popped got %0d exp 12", words_popped); end
    step();
  endtask

  task automatic test_underflow();
    start_frame();
    bus.input_req = 1'b1;
    step();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL under_set got %b exp 1", underflow); end
    checks++; if (words_popped !== 16'd0) begin errors++; $display("FAIL under_popped got %0d exp 0", words_popped); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL under_level got %0d exp 0", level); end
    step();
    bus.input_req = 1'b0;
    start_frame();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL under_conv_start_in_run got %b exp 1", underflow); end
    checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL under_run_tready got %b exp 1", bus.s_axis_tready); end
    bus.s_axis_tdata  = pat(8'hA0, 0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b1;
    step();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checks++; if (bus.fm !== pat(8'hA0, 0)) begin errors++; $display("FAIL under_fm got %h exp %h", bus.fm, pat(8'hA0, 0)); end
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL under_frame_done got %b exp 1", frame_done); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL under_sticky got %b exp 1", underflow); end
    checks++; if (words_popped !== 16'd1) begin errors++; $display("FAIL under_popped_end got %0d exp 1", words_popped); end
    step();
    start_frame();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL under_clear got %b exp 0", underflow); end
    checks++; if (words_popped !== 16'd0) begin errors++; $display("FAIL under_popped_clear got %0d exp 0", words_popped); end
  endtask

  task automatic test_reset_mid_drain();
    bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.s_axis_tdata = pat(8'hB0, k);
      bus.s_axis_tlast = (k == 2);
      step();
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rst_pre_level got %0d exp 3", level); end
    checks++; if (bus.ifm_read !== 1'b1) begin errors++; $display("FAIL rst_pre_ifm_read got %b exp 1", bus.ifm_read); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.ifm_read !== 1'b0) begin errors++; $display("FAIL rst_async_ifm_read got %b exp 0", bus.ifm_read); end
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_async_tready got %b exp 0", bus.s_axis_tready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_async_level got %0d exp 0", level); end
    checks++; if (bus.fm !== 512'd0) begin errors++; $display("FAIL rst_async_fm got %h exp 0", bus.fm); end
    step();
    step();
    rst = 1'b0;
    step();
    start_frame();
    checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_new_tready got %b exp 1", bus.s_axis_tready); end
    bus.s_axis_tdata  = pat(8'hC0, 0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b1;
    step();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL rst_new_level got %0d exp 1", level); end
    checks++; if (bus.fm !== pat(8'hC0, 0)) begin errors++; $display("FAIL rst_new_fm got %h exp %h", bus.fm, pat(8'hC0, 0)); end
    bus.input_req = 1'b1;
    step();
    bus.input_req = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rst_new_frame_done got %b exp 1", frame_done); end
    checks++; if (words_popped !== 16'd1) begin errors++; $display("FAIL rst_new_popped got %0d exp 1", words_popped); end
    step();
  endtask

  task automatic test_outside_frame();
    bus.s_axis_tdata  = pat(8'h90, 0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) step();
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL out_idle_tready got %b exp 0", bus.s_axis_tready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL out_idle_level got %0d exp 0", level); end
    start_frame();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL out_start_edge_level got %0d exp 0", level); end
    step();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL out_first_level got %0d exp 1", level); end
    bus.s_axis_tdata = pat(8'h90, 1);
    bus.s_axis_tlast = 1'b1;
    step();
    bus.s_axis_tdata = pat(8'h90, 2);
    bus.s_axis_tlast = 1'b0;
    step();
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL out_drain_tready got %b exp 0", bus.s_axis_tready); end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL out_drain_level got %0d exp 2", level); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.fm !== pat(8'h90, i)) begin errors++; $display("FAIL out_fm%0d got %h exp %h", i, bus.fm, pat(8'h90, i)); end
      bus.input_req = 1'b1;
      step();
      bus.input_req = 1'b0;
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL out_frame_done got %b exp 1", frame_done); end
    checks++; if (words_popped !== 16'd2) begin errors++; $display("FAIL out_popped got %0d exp 2", words_popped); end
    step();
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL out_after_tready got %b exp 0", bus.s_axis_tready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL out_after_level got %0d exp 0", level); end
    bus.s_axis_tvalid = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    conv_start        = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.input_req     = 1'b0;
    test_reset();
    test_basic_frame();
    test_full_backpressure();
    test_simultaneous();
    test_underflow();
    test_reset_mid_drain();
    test_outside_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
